// File: rtl/seq_det_pkg.sv
// Shared constants and types for the serial pattern detector family.
// The configuration record is sized for the widest supported pattern.
package seq_det_pkg;

    localparam int PAT_MAX = 32;
    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;

    // Bits needed to count 0..n inclusive.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_FILL_W = fill_width(DEF_PAT_W);

    typedef struct packed {
        logic [PAT_MAX-1:0] pattern;
        logic               overlap;
    } cfg_t;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating event counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered one-cycle match pulse and saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b0110,
    parameter logic             OVL_RST = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int FW = fill_width(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

    cfg_t             cfg_q, cfg_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;

    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic             hit;

    always_comb begin
        hist_n  = {hist_q[PAT_W-2:0], in};
        fill_n  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        hit     = in_valid && (fill_n == FILL_MAX)
                  && (PAT_MAX'(hist_n) == cfg_q.pattern);

        cfg_d   = cfg_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        // A config write restarts detection and swallows any same-cycle bit.
        if (cfg_we) begin
            cfg_d.pattern = PAT_MAX'(cfg_pattern);
            cfg_d.overlap = cfg_overlap;
            hist_d        = '0;
            fill_d        = '0;
        end else if (in_valid) begin
            hist_d  = hist_n;
            fill_d  = (hit && !cfg_q.overlap) ? '0 : fill_n;
            match_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.pattern <= PAT_MAX'(PAT_RST);
            cfg_q.overlap <= OVL_RST;
            hist_q        <= '0;
            fill_q        <= '0;
            match_q       <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    // Fed with the next match value so the count moves on the same edge.
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (match_d),
        .cnt_o (match_cnt)
    );

    assign match = match_q;
    assign busy  = (fill_q != '0);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector with hand-computed expectations.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       match;
    logic [2:0] match_cnt;
    logic       busy;

    int total  = 0;
    int passed = 0;

    seq_pattern_detector #(
        .PAT_W   (4),
        .PAT_RST (4'b0110),
        .OVL_RST (1'b1),
        .CNT_W   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_m, input string tag);
        in_valid = 1'b1;
        in = b;
        tick();
        chk(tag, 32'(match), 32'(exp_m));
    endtask

    task automatic idle(input string tag);
        tick();
        chk(tag, 32'(match), 32'd0);
    endtask

    task automatic cfg(input logic [3:0] p, input logic o, input logic clr);
        cfg_we = 1'b1;
        cfg_pattern = p;
        cfg_overlap = o;
        cnt_clr = clr;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_we = 1'b0;
        cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        // Reset and default pattern 0110, overlap on
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        send(1'b0, 1'b0, "def_b0");
        chk("def_busy", 32'(busy), 32'd1);
        send(1'b1, 1'b0, "def_b1");
        send(1'b1, 1'b0, "def_b2");
        send(1'b0, 1'b1, "def_b3");
        chk("def_cnt", 32'(match_cnt), 32'd1);
        idle("def_after");
        chk("def_cnt_hold", 32'(match_cnt), 32'd1);

        // Overlap: 0110110 -> matches on bits 4 and 7
        cfg(4'b0110, 1'b1, 1'b1);
        chk("ovl_cfg_busy", 32'(busy), 32'd0);
        chk("ovl_cfg_cnt", 32'(match_cnt), 32'd0);
        send(1'b0, 1'b0, "ovl_b0");
        send(1'b1, 1'b0, "ovl_b1");
        send(1'b1, 1'b0, "ovl_b2");
        send(1'b0, 1'b1, "ovl_b3");
        send(1'b1, 1'b0, "ovl_b4");
        send(1'b1, 1'b0, "ovl_b5");
        send(1'b0, 1'b1, "ovl_b6");
        chk("ovl_cnt", 32'(match_cnt), 32'd2);

        // Non-overlap replay -> single match, count continues
        cfg(4'b0110, 1'b0, 1'b0);
        chk("nov_cfg_cnt", 32'(match_cnt), 32'd2);
        send(1'b0, 1'b0, "nov_b0");
        send(1'b1, 1'b0, "nov_b1");
        send(1'b1, 1'b0, "nov_b2");
        send(1'b0, 1'b1, "nov_b3");
        chk("nov_busy0", 32'(busy), 32'd0);
        send(1'b1, 1'b0, "nov_b4");
        send(1'b1, 1'b0, "nov_b5");
        send(1'b0, 1'b0, "nov_b6");
        chk("nov_cnt", 32'(match_cnt), 32'd3);

        // Programmable pattern 1011 with overlap
        cfg(4'b1011, 1'b1, 1'b1);
        send(1'b1, 1'b0, "p_b0");
        send(1'b0, 1'b0, "p_b1");
        send(1'b1, 1'b0, "p_b2");
        send(1'b1, 1'b1, "p_b3");
        send(1'b0, 1'b0, "p_b4");
        send(1'b1, 1'b0, "p_b5");
        send(1'b1, 1'b1, "p_b6");
        chk("p_cnt", 32'(match_cnt), 32'd2);

        // Bit arriving with cfg_we is discarded
        in_valid = 1'b1; in = 1'b1;
        cfg(4'b1011, 1'b1, 1'b0);
        chk("disc_match", 32'(match), 32'd0);
        chk("disc_busy", 32'(busy), 32'd0);
        send(1'b0, 1'b0, "disc_b0");
        send(1'b1, 1'b0, "disc_b1");
        send(1'b1, 1'b0, "disc_b2");
        send(1'b1, 1'b0, "disc_b3");
        chk("disc_cnt", 32'(match_cnt), 32'd2);

        // Gaps in in_valid
        cfg(4'b0110, 1'b1, 1'b1);
        send(1'b0, 1'b0, "gap_b0");
        send(1'b1, 1'b0, "gap_b1");
        for (int i = 0; i < 3; i++) begin
            in = ~in;
            idle("gap_idle");
            chk("gap_busy", 32'(busy), 32'd1);
        end
        send(1'b1, 1'b0, "gap_b2");
        send(1'b0, 1'b1, "gap_b3");
        chk("gap_cnt", 32'(match_cnt), 32'd1);

        // Saturation with 1111 and 20 ones
        cfg(4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, (i >= 3) ? 1'b1 : 1'b0, "sat_m");
            chk("sat_cnt", 32'(match_cnt), (i < 3) ? 32'd0 : ((i - 2 > 7) ? 32'd7 : 32'(i - 2)));
        end
        chk("sat_final", 32'(match_cnt), 32'd7);
        cnt_clr = 1'b1;
        send(1'b1, 1'b1, "clr_match");
        chk("clr_cnt", 32'(match_cnt), 32'd0);
        send(1'b1, 1'b1, "clr_next");
        chk("clr_next_cnt", 32'(match_cnt), 32'd1);

        // Mid-operation reset restores pattern and overlap defaults
        cfg(4'b1001, 1'b0, 1'b0);
        send(1'b0, 1'b0, "mr_b0");
        send(1'b1, 1'b0, "mr_b1");
        send(1'b1, 1'b0, "mr_b2");
        rst = 1'b1;
        tick();
        chk("mr_match", 32'(match), 32'd0);
        chk("mr_cnt", 32'(match_cnt), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        send(1'b0, 1'b0, "mr_b3");
        send(1'b1, 1'b0, "mr_b4");
        send(1'b1, 1'b0, "mr_b5");
        send(1'b0, 1'b1, "mr_b6");
        send(1'b1, 1'b0, "mr_b7");
        send(1'b1, 1'b0, "mr_b8");
        send(1'b0, 1'b1, "mr_b9");
        chk("mr_cnt_end", 32'(match_cnt), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
